// File: rtl/fetch_prefetch_q.sv
// Purpose : Y86-64 fetch stage; FETCH_W-byte imem reads feed a byte-wide prefetch
//           queue, and variable-length instructions are decoded from the queue head.
// Latency : imem data is enqueued 1 cycle after the request; f_valid is combinational
//           from the queue head (reset release to first 1-byte instruction: 2 cycles).
// Backpr. : decode stalls via d_ready=0 (outputs held); fetch stops when the queue,
//           counting the read in flight, has fewer than FETCH_W free bytes.
// Ports   : clk/rst (sync, active high); imem_req/imem_addr/imem_rdata memory port;
//           M_icode/M_cnd/M_valA mispredict redirect; W_icode/W_valM ret target;
//           f_valid/d_ready handshake with decoded f_* fields and predPC.
module fetch_prefetch_q #(
    parameter int FETCH_W    = 4,
    parameter int QDEPTH     = 16,
    parameter int IMEM_BYTES = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [63:0]          imem_addr,
    input  logic [8*FETCH_W-1:0] imem_rdata,
    input  logic [3:0]           M_icode,
    input  logic                 M_cnd,
    input  logic [63:0]          M_valA,
    input  logic [3:0]           W_icode,
    input  logic [63:0]          W_valM,
    output logic                 f_valid,
    input  logic                 d_ready,
    output logic [3:0]           f_icode,
    output logic [3:0]           f_ifun,
    output logic [3:0]           f_rA,
    output logic [3:0]           f_rB,
    output logic [63:0]          f_valC,
    output logic [63:0]          f_valP,
    output logic [63:0]          f_PC,
    output logic [2:0]           f_stat,
    output logic [63:0]          predPC
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {RUN, WAIT_RET, STOP} state_t;

    state_t               state;
    logic [7:0]           q_dat [QDEPTH];
    logic                 q_bad [QDEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic [63:0]          head_pc, fetch_pc;
    logic [1:0]           epoch, infl_epoch;
    logic                 infl;
    logic [FETCH_W-1:0]   infl_bad, req_bad;
    logic [64:0]          req_sum [FETCH_W];
    logic [CW:0]          occ;
    logic                 issue, enq, xfer, redirect, ret_done;

    logic [7:0]  hb [10];
    logic [9:0]  hb_present, hb_bad;
    logic [3:0]  raw_icode, ilen;
    logic        has_regs, bad_any, raw_valid;
    logic [63:0] raw_valc, val_p;
    logic [2:0]  raw_stat;

    // Fetch request: the in-flight read is counted so a full queue is never overrun.
    // A byte is bad if its address is beyond imem or the address sum carried past 2^64.
    always_comb begin
        occ = {1'b0, count} + (infl ? (CW+1)'(FETCH_W) : (CW+1)'(0));
        for (int k = 0; k < FETCH_W; k++) begin
            req_sum[k] = {1'b0, fetch_pc} + 65'(k);
            req_bad[k] = req_sum[k][64] || (req_sum[k][63:0] >= 64'(IMEM_BYTES));
        end
    end

    assign issue     = !rst && (state == RUN) && (occ <= (CW+1)'(QDEPTH - FETCH_W));
    // A read wholly outside imem is never issued; its bytes still enter as bad.
    assign imem_req  = issue && !req_bad[0];
    assign imem_addr = fetch_pc;
    assign enq       = infl && (infl_epoch == epoch);

    // Head window; bytes not yet present read as zero so held outputs stay stable.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            hb_present[i] = (CW'(i) < count);
            hb[i]         = hb_present[i] ? q_dat[rd_ptr + PW'(i)] : 8'h00;
            hb_bad[i]     = hb_present[i] & q_bad[rd_ptr + PW'(i)];
        end
    end

    assign raw_icode = hb[0][7:4];

    always_comb begin
        ilen     = 4'd1;
        has_regs = 1'b0;
        raw_valc = 64'd0;
        case (raw_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin ilen = 4'd2; has_regs = 1'b1; end
            4'h7, 4'h8: begin
                ilen     = 4'd9;
                raw_valc = {hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2], hb[1]};
            end
            4'h3, 4'h4, 4'h5: begin
                ilen     = 4'd10;
                has_regs = 1'b1;
                raw_valc = {hb[9], hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2]};
            end
            default: ilen = 4'd1;
        endcase
        bad_any = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((4'(i) < ilen) && hb_bad[i]) bad_any = 1'b1;
        end
    end

    // Bad bytes only follow good ones, so an ADR instruction is presentable as soon
    // as its first bad byte has arrived.
    assign raw_valid = (state == RUN) && (count != '0) && ((count >= CW'(ilen)) || bad_any);
    assign val_p     = head_pc + 64'(ilen);
    assign raw_stat  = bad_any ? S_ADR :
                       (raw_icode >= 4'hC) ? S_INS :
                       (raw_icode == 4'h0) ? S_HLT : S_AOK;

    assign xfer     = raw_valid && d_ready;
    assign redirect = (M_icode == 4'h7) && !M_cnd;
    assign ret_done = (state == WAIT_RET) && (W_icode == 4'h9);

    always_comb begin
        f_valid = raw_valid;
        f_PC    = head_pc;
        f_icode = 4'h1;
        f_ifun  = 4'h0;
        f_rA    = 4'hF;
        f_rB    = 4'hF;
        f_valC  = 64'd0;
        f_valP  = 64'd0;
        f_stat  = S_AOK;
        predPC  = 64'd0;
        if (raw_valid) begin
            f_icode = raw_icode;
            f_ifun  = hb[0][3:0];
            f_rA    = has_regs ? hb[1][7:4] : 4'hF;
            f_rB    = has_regs ? hb[1][3:0] : 4'hF;
            f_valC  = raw_valc;
            f_valP  = val_p;
            f_stat  = raw_stat;
            predPC  = (raw_icode == 4'h7 || raw_icode == 4'h8) ? raw_valc : val_p;
        end
    end

    // Control state. Later assignments in the priority chain override the
    // default pointer/count updates, so a flush wins over a same-cycle pop/enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_pc    <= 64'd0;
            fetch_pc   <= 64'd0;
            epoch      <= 2'd0;
            infl       <= 1'b0;
            infl_epoch <= 2'd0;
            infl_bad   <= '0;
        end else begin
            infl       <= issue;
            infl_epoch <= epoch;
            infl_bad   <= req_bad;
            if (issue) fetch_pc <= fetch_pc + 64'(FETCH_W);
            if (enq)   wr_ptr   <= wr_ptr + PW'(FETCH_W);
            if (xfer) begin
                rd_ptr  <= rd_ptr + PW'(ilen);
                head_pc <= val_p;
            end
            count <= count + (enq ? CW'(FETCH_W) : CW'(0)) - (xfer ? CW'(ilen) : CW'(0));

            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                epoch    <= epoch + 2'd1;
                head_pc  <= M_valA;
                fetch_pc <= M_valA;
                state    <= RUN;
            end else if (ret_done) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                head_pc  <= W_valM;
                fetch_pc <= W_valM;
                state    <= RUN;
            end else if (xfer) begin
                if (raw_stat != S_AOK) begin
                    state <= STOP;
                end else if (raw_icode == 4'h7 || raw_icode == 4'h8) begin
                    rd_ptr   <= '0;
                    wr_ptr   <= '0;
                    count    <= '0;
                    epoch    <= epoch + 2'd1;
                    head_pc  <= raw_valc;
                    fetch_pc <= raw_valc;
                end else if (raw_icode == 4'h9) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                    epoch  <= epoch + 2'd1;
                    state  <= WAIT_RET;
                end
            end
        end
    end

    // Queue storage; bad bytes are stored as zero so they never look like real code.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < FETCH_W; k++) begin
                q_dat[wr_ptr + PW'(k)] <= infl_bad[k] ? 8'h00 : imem_rdata[8*k +: 8];
                q_bad[wr_ptr + PW'(k)] <= infl_bad[k];
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Bench for fetch_prefetch_q: directed programs in a behavioural 1-cycle imem,
// expected decode records held in a table, plus hand sequences for redirects,
// ret wait, ADR/INS stops, stall hold and mid-read reset.
module tb_fetch_prefetch_q;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [63:0]   imem_addr;
    logic [8*FW-1:0] imem_rdata = '0;
    logic [3:0]    M_icode, W_icode;
    logic          M_cnd;
    logic [63:0]   M_valA, W_valM;
    logic          f_valid, d_ready;
    logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
    logic [63:0]   f_valC, f_valP, f_PC, predPC;
    logic [2:0]    f_stat;

    always #5 clk = ~clk;

    fetch_prefetch_q #(.FETCH_W(FW), .QDEPTH(16), .IMEM_BYTES(2048)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM),
        .f_valid(f_valid), .d_ready(d_ready),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .f_PC(f_PC), .f_stat(f_stat),
        .predPC(predPC)
    );

    // Instruction memory: read data appears the cycle after the request.
    logic [7:0] mem [2048];
    int bad_req_cnt = 0;
    always @(posedge clk) begin
        logic [8*FW-1:0] rd;
        logic [63:0]     a;
        rd = '0;
        if (imem_req) begin
            if (imem_addr >= 64'd2048) bad_req_cnt++;
            for (int k = 0; k < FW; k++) begin
                a = imem_addr + 64'(k);
                rd[8*k +: 8] = (a < 64'd2048) ? mem[a[10:0]] : 8'hEE;
            end
            imem_rdata <= rd;
        end
    end

    typedef struct {
        logic [63:0] pc;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        logic [63:0] pred;
    } vec_t;
    vec_t vec [11];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (!f_valid && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (!f_valid) begin
            n_total++;
            $display("FAIL wait_valid: f_valid=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic check_vec(input int i, output int lat);
        wait_valid(40, lat);
        if (f_valid) begin
            chk($sformatf("v%0d f_PC", i),    f_PC,   vec[i].pc);
            chk($sformatf("v%0d f_icode", i), f_icode, vec[i].icode);
            chk($sformatf("v%0d f_ifun", i),  f_ifun, vec[i].ifun);
            chk($sformatf("v%0d f_rA", i),    f_rA,   vec[i].ra);
            chk($sformatf("v%0d f_rB", i),    f_rB,   vec[i].rb);
            chk($sformatf("v%0d f_valC", i),  f_valC, vec[i].valc);
            chk($sformatf("v%0d f_valP", i),  f_valP, vec[i].valp);
            chk($sformatf("v%0d f_stat", i),  f_stat, vec[i].stat);
            chk($sformatf("v%0d predPC", i),  predPC, vec[i].pred);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " f_valid"},  f_valid,  0);
        chk({tag, " imem_req"}, imem_req, 0);
        chk({tag, " f_stat"},   f_stat,   1);
        chk({tag, " f_valC"},   f_valC,   0);
        chk({tag, " f_valP"},   f_valP,   0);
        chk({tag, " f_PC"},     f_PC,     0);
        chk({tag, " predPC"},   predPC,   0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    endtask

    // irmovq $0xA,%rsp @0 ; nop @10 ; halt @11
    task automatic load_img1();
        clear_mem();
        mem[0] = 8'h30; mem[1] = 8'hF4; mem[2] = 8'h0A;
        mem[10] = 8'h10; mem[11] = 8'h00;
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1;
        M_icode = 4'h0; M_cnd = 1'b1; M_valA = 64'd0;
        W_icode = 4'h0; W_valM = 64'd0;
        repeat (2) @(negedge clk);
        if (check) check_reset_vals("reset");
        rst = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        logic seen_v, seen_r;
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int j = 0; j < n; j++) begin
            seen_v |= f_valid;
            seen_r |= imem_req;
            @(negedge clk);
        end
        chk({tag, " f_valid"},  seen_v, 0);
        chk({tag, " imem_req"}, seen_r, 0);
    endtask

    initial begin
        int lat;
        //          pc      ic    ifun  rA    rB    valC        valP     stat  predPC
        vec[0]  = '{64'd0,  4'h3, 4'h0, 4'hF, 4'h4, 64'hA,      64'd10,  3'd1, 64'd10};
        vec[1]  = '{64'd10, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,      64'd11,  3'd1, 64'd11};
        vec[2]  = '{64'd11, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0,      64'd12,  3'd2, 64'd12};
        vec[3]  = '{64'd0,  4'h7, 4'h0, 4'hF, 4'hF, 64'h40,     64'd9,   3'd1, 64'h40};
        vec[4]  = '{64'h40, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0,      64'h41,  3'd1, 64'h41};
        vec[5]  = '{64'd9,  4'h2, 4'h0, 4'h1, 4'h2, 64'd0,      64'd11,  3'd1, 64'd11};
        vec[6]  = '{64'd0,  4'h8, 4'h0, 4'hF, 4'hF, 64'h20,     64'd9,   3'd1, 64'h20};
        vec[7]  = '{64'h20, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,      64'h21,  3'd1, 64'h21};
        vec[8]  = '{64'd9,  4'h6, 4'h0, 4'h2, 4'h3, 64'd0,      64'd11,  3'd1, 64'd11};
        vec[9]  = '{64'd0,  4'h7, 4'h0, 4'hF, 4'hF, 64'd2046,   64'd9,   3'd1, 64'd2046};
        vec[10] = '{64'd0,  4'hC, 4'h0, 4'hF, 4'hF, 64'd0,      64'd1,   3'd4, 64'd1};

        d_ready = 1'b1;

        // 1: straight-line program, then halt stops everything.
        load_img1();
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            check_vec(i, lat);
            if (i == 0) chk("irmovq latency", lat, 4);
            @(negedge clk);
        end
        idle_check("after halt", 4);

        // 2: decode stalled; outputs held, fetch stops at a full queue.
        load_img1();
        d_ready = 1'b0;
        do_reset(1'b0);
        check_vec(0, lat);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("hold f_valid", f_valid, 1);
            chk("hold f_PC",    f_PC,    0);
            chk("hold f_valC",  f_valC,  64'hA);
        end
        chk("full imem_req", imem_req, 0);
        d_ready = 1'b1;
        @(negedge clk);
        check_vec(1, lat);
        @(negedge clk);
        check_vec(2, lat);
        @(negedge clk);

        // 3: jmp 0x40 predicted taken, then M-stage mispredict back to 9.
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h40;
        mem[9] = 8'h20; mem[10] = 8'h12;
        for (int a = 8'h40; a < 8'h50; a++) mem[a] = 8'h10;
        do_reset(1'b0);
        check_vec(3, lat);
        @(negedge clk);
        check_vec(4, lat);
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'd9;
        @(negedge clk);
        M_icode = 4'h0; M_cnd = 1'b1;
        chk("redirect f_PC", f_PC, 9);
        chk("redirect flushed", f_valid, 0);
        check_vec(5, lat);
        @(negedge clk);

        // 4: call 0x20, ret waits for W-stage return address.
        clear_mem();
        mem[0] = 8'h80; mem[1] = 8'h20;
        mem[8'h20] = 8'h90;
        mem[9] = 8'h60; mem[10] = 8'h23;
        do_reset(1'b0);
        check_vec(6, lat);
        @(negedge clk);
        check_vec(7, lat);
        @(negedge clk);
        idle_check("wait_ret", 3);
        W_icode = 4'h9; W_valM = 64'd9;
        @(negedge clk);
        W_icode = 4'h0;
        check_vec(8, lat);
        @(negedge clk);

        // 5a: irmovq straddling the end of imem -> ADR, then stop.
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'hFE; mem[2] = 8'h07;
        mem[2046] = 8'h30; mem[2047] = 8'hF1;
        do_reset(1'b0);
        check_vec(9, lat);
        @(negedge clk);
        wait_valid(40, lat);
        chk("adr f_stat",  f_stat,  3);
        chk("adr f_PC",    f_PC,    2046);
        chk("adr f_icode", f_icode, 3);
        chk("adr f_valP",  f_valP,  2056);
        @(negedge clk);
        idle_check("after adr", 3);
        chk("no imem read past end", bad_req_cnt, 0);

        // 5b: invalid icode at 0, minimum latency.
        clear_mem();
        mem[0] = 8'hC0;
        do_reset(1'b0);
        check_vec(10, lat);
        chk("ins latency", lat, 2);
        @(negedge clk);
        idle_check("after ins", 3);

        // 6: reset while a read is in flight.
        load_img1();
        do_reset(1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        check_vec(0, lat);
        chk("midrst latency", lat, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
